// File: rtl/ars_bk_shift_pipe.sv
// Iterative SMS4 block-state shift register: load a block, shift in one round word per cycle,
// then hand the final block out over ready/valid. Define ARS_BK_SHIFT_REVERSE_EN to word-reverse block_out.
module ars_bk_shift_pipe #(
    parameter int unsigned BWIDTH  = 32,
    parameter int unsigned NWORDS  = 4,
    parameter int unsigned NROUNDS = 32,
    parameter int unsigned CNTW    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NWORDS*BWIDTH-1:0]  block_in,
    input  logic [BWIDTH-1:0]         round_word,
    output logic [NWORDS*BWIDTH-1:0]  x_out,
    output logic [CNTW-1:0]           round_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NWORDS*BWIDTH-1:0]  block_out
);

    localparam logic [CNTW-1:0] LastIdx = CNTW'(NROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                      state_q;
    logic [BWIDTH-1:0]           x_q [NWORDS];
    logic [BWIDTH-1:0]           x_shift [NWORDS];
    logic [CNTW-1:0]             idx_q;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic [NWORDS*BWIDTH-1:0]    block_out_q;
    logic [NWORDS*BWIDTH-1:0]    final_blk;

    always_comb begin
        for (int i = 0; i < NWORDS - 1; i++) begin
            x_shift[i] = x_q[i + 1];
        end
        x_shift[NWORDS-1] = round_word;
    end

    // Word 0 sits in the MSBs of every packed view.
    always_comb begin
        x_out     = '0;
        final_blk = '0;
        for (int i = 0; i < NWORDS; i++) begin
            x_out[(NWORDS-i)*BWIDTH-1 -: BWIDTH] = x_q[i];
`ifdef ARS_BK_SHIFT_REVERSE_EN
            final_blk[(NWORDS-i)*BWIDTH-1 -: BWIDTH] = x_shift[NWORDS-1-i];
`else
            final_blk[(NWORDS-i)*BWIDTH-1 -: BWIDTH] = x_shift[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            for (int i = 0; i < NWORDS; i++) begin
                x_q[i] <= '0;
            end
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            block_out_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            x_q[i] <= block_in[(NWORDS-i)*BWIDTH-1 -: BWIDTH];
                        end
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    x_q <= x_shift;
                    // Index saturates on the last round so it never reaches NROUNDS.
                    if (idx_q == LastIdx) begin
                        out_valid_q <= 1'b1;
                        block_out_q <= final_blk;
                        state_q     <= StDone;
                    end else begin
                        idx_q <= idx_q + CNTW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign round_idx = idx_q;
    assign out_valid = out_valid_q;
    assign block_out = block_out_q;

endmodule

// File: tb/tb_ars_bk_shift_pipe.sv
// Scoreboard bench for ars_bk_shift_pipe; the external round function is modelled here
// (plain rotate, SMS4 round, and a simple index-dependent mix).
module tb_ars_bk_shift_pipe;

    localparam int NR = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] block_in;
    logic [31:0]  round_word;
    logic [127:0] x_out;
    logic [5:0]   round_idx;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] block_out;

    ars_bk_shift_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .block_in   (block_in),
        .round_word (round_word),
        .x_out      (x_out),
        .round_idx  (round_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .block_out  (block_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] sbox [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    logic [31:0] rk [32];
    logic [31:0] ks [36];
    int          mode;

    function automatic logic [31:0] rol(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox[a[31:24]], sbox[a[23:16]], sbox[a[15:8]], sbox[a[7:0]]};
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    // External round function: 0 = rotate, 1 = SMS4 round, 2 = index-dependent mix.
    function automatic logic [31:0] rw(input int m, input logic [31:0] x0, input logic [31:0] x1,
                                       input logic [31:0] x2, input logic [31:0] x3,
                                       input logic [5:0] idx);
        case (m)
            1:       return x0 ^ t_enc(x1 ^ x2 ^ x3 ^ rk[idx[4:0]]);
            2:       return x0 ^ rol(x3, 5) ^ 32'(idx) ^ 32'h9e3779b9;
            default: return x0;
        endcase
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input int m);
        logic [31:0] w [4];
        logic [31:0] nw;
        for (int i = 0; i < 4; i++) w[i] = blk[127-32*i -: 32];
        for (int r = 0; r < NR; r++) begin
            nw   = rw(m, w[0], w[1], w[2], w[3], 6'(r));
            w[0] = w[1];
            w[1] = w[2];
            w[2] = w[3];
            w[3] = nw;
        end
`ifdef ARS_BK_SHIFT_REVERSE_EN
        return {w[3], w[2], w[1], w[0]};
`else
        return {w[0], w[1], w[2], w[3]};
`endif
    endfunction

    always_comb round_word = rw(mode, x_out[127:96], x_out[95:64], x_out[63:32], x_out[31:0],
                                round_idx);

    int           checks = 0;
    int           errors = 0;
    int           cyc_n = 0;
    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic [127:0] next_exp;
    bit           in_run = 0;
    int           run_pos = 0;
    bit           ov_seen = 0;
    bit           chk_gap = 0;
    int           last_acc = -1;
    int           last_hs = -1;
    bit           tick_acc;
    bit           tick_hs;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observe the cycle just before the rising edge, then advance to the next falling edge.
    task automatic tick();
        logic [127:0] e;
        int           a;
        tick_acc = 0;
        tick_hs  = 0;
        if (in_run) begin
            chk("round_idx_seq", 128'(round_idx), 128'(run_pos));
            chk("round_idx_max", 128'(round_idx < 6'(NR)), 128'(1));
            run_pos++;
            if (run_pos == NR) in_run = 0;
        end
        if (out_valid && !rst) begin
            if (!ov_seen) begin
                ov_seen = 1;
                if (acc_q.size() > 0) begin
                    a = acc_q.pop_front();
                    chk("latency", 128'(cyc_n - a), 128'(NR));
                end else begin
                    chk("unexpected_out_valid", 128'(1), 128'(0));
                end
            end
            if (out_ready) begin
                tick_hs = 1;
                ov_seen = 0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("block_out", block_out, e);
                end else begin
                    chk("unexpected_output", 128'(1), 128'(0));
                end
                if (chk_gap && last_hs >= 0) chk("out_spacing", 128'(cyc_n - last_hs), 128'(NR + 2));
                last_hs = cyc_n;
            end
        end
        if (in_valid && in_ready && !rst) begin
            tick_acc = 1;
            exp_q.push_back(next_exp);
            acc_q.push_back(cyc_n + 1);
            if (chk_gap && last_acc >= 0) chk("accept_spacing", 128'(cyc_n + 1 - last_acc), 128'(NR + 2));
            last_acc = cyc_n + 1;
            in_run   = 1;
            run_pos  = 0;
        end
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic wait_accept();
        int n = 0;
        tick();
        while (!tick_acc && n < 200) begin
            tick();
            n++;
        end
        if (!tick_acc) chk("accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_out();
        int n = 0;
        tick();
        while (!tick_hs && n < 200) begin
            tick();
            n++;
        end
        if (!tick_hs) chk("output_timeout", 128'(0), 128'(1));
    endtask

    task automatic send(input logic [127:0] blk, input logic [127:0] e);
        block_in = blk;
        next_exp = e;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        block_in = '0;
    endtask

    logic [127:0] blk;
    logic [127:0] bexp;
    logic [127:0] b2b [3];
    logic [31:0]  ck;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; block_in = '0; mode = 0; next_exp = '0;

        // SMS4 key schedule for key 0123456789ABCDEFFEDCBA9876543210.
        ks[0] = 32'h01234567 ^ 32'ha3b1bac6;
        ks[1] = 32'h89abcdef ^ 32'h56aa3350;
        ks[2] = 32'hfedcba98 ^ 32'h677d9197;
        ks[3] = 32'h76543210 ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            ck = {8'((4*i)*7), 8'((4*i+1)*7), 8'((4*i+2)*7), 8'((4*i+3)*7)};
            ks[i+4] = ks[i] ^ t_key(ks[i+1] ^ ks[i+2] ^ ks[i+3] ^ ck);
            rk[i] = ks[i+4];
        end

        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_round_idx", 128'(round_idx), 128'(0));
        chk("reset_x_out", x_out, 128'(0));
        chk("reset_block_out", block_out, 128'(0));
        tick();
        chk("reset_in_ready", 128'(in_ready), 128'(1));

        // Rotate: 32 one-word rotations return the original word order.
        mode = 0;
        blk = 128'h00000000_11111111_22222222_33333333;
`ifdef ARS_BK_SHIFT_REVERSE_EN
        bexp = 128'h33333333_22222222_11111111_00000000;
`else
        bexp = blk;
`endif
        send(blk, bexp);
        wait_out();

        // SMS4 known answer.
        mode = 1;
`ifdef ARS_BK_SHIFT_REVERSE_EN
        bexp = 128'h681EDF34_D206965E_86B3E94F_536E4246;
`else
        bexp = 128'h536E4246_86B3E94F_D206965E_681EDF34;
`endif
        send(128'h0123456789ABCDEFFEDCBA9876543210, bexp);
        wait_out();

        // Backpressure in DONE with ignored in_valid pulses.
        mode = 2;
        blk = 128'hdeadbeef_0badf00d_c0ffee00_12345678;
        bexp = model(blk, 2);
        out_ready = 1'b0;
        send(blk, bexp);
        for (int n = 0; n < 100 && !out_valid; n++) tick();
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            block_in = {4{32'(i) ^ 32'h5a5a5a5a}};
            chk("bp_block_out", block_out, bexp);
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        chk("bp_queue_empty", 128'(exp_q.size()), 128'(0));

        // Back-to-back blocks with in_valid held high.
        b2b[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        b2b[1] = 128'hfedcba98_76543210_01234567_89abcdef;
        b2b[2] = 128'ha5a5a5a5_5a5a5a5a_3c3c3c3c_c3c3c3c3;
        chk_gap = 1; last_acc = -1; last_hs = -1;
        in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            block_in = b2b[b];
            next_exp = model(b2b[b], 2);
            wait_accept();
        end
        in_valid = 1'b0;
        wait_out();
        chk_gap = 0;
        chk("b2b_queue_empty", 128'(exp_q.size()), 128'(0));

        // Reset in the middle of RUN at round_idx = 10.
        mode = 0;
        send(128'h13579bdf_2468ace0_0f0f0f0f_f0f0f0f0, 128'h0);
        for (int n = 0; n < 50 && round_idx != 6'd10; n++) tick();
        chk("pre_reset_idx", 128'(round_idx), 128'(10));
        in_run = 0;
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("mid_reset_out_valid", 128'(out_valid), 128'(0));
        chk("mid_reset_round_idx", 128'(round_idx), 128'(0));
        chk("mid_reset_x_out", x_out, 128'(0));
        chk("mid_reset_block_out", block_out, 128'(0));
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        acc_q.delete();
        ov_seen = 0;
        tick();
        chk("post_reset_in_ready", 128'(in_ready), 128'(1));
        chk("post_reset_out_valid", 128'(out_valid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
